// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
// Sequences the N+S and E+W lane pairs through green, yellow and all-red
// clearance phases. In day mode a green is held while the cross street has
// no waiting car. In night mode the greens alternate on a short fixed
// duration.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   night_mode  1 = night schedule; sampled only on entry to a green
//   car_ns      car waiting on the N or S approach (level)
//   car_ew      car waiting on the E or W approach (level)
//   laneOutput  light word WWSSEENN; per light 11 = green, 01 = yellow, 00 = red
//   loadTime    duration loaded on entry to the current phase
//   timer       cycles remaining in the current phase, minus 1
//   phase       current state encoding
//   phase_done  one-cycle pulse in the first cycle of every new phase
module traffic_phase_sequencer #(
    parameter int unsigned GREEN_TIME   = 60,
    parameter int unsigned YELLOW_TIME  = 5,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned NIGHT_TIME   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night_mode,
    input  logic       car_ns,
    input  logic       car_ew,
    output logic [7:0] laneOutput,
    output logic [6:0] loadTime,
    output logic [6:0] timer,
    output logic [2:0] phase,
    output logic       phase_done
);

    localparam int unsigned TW = 7;

    localparam logic [TW-1:0] GREEN_DUR  = TW'(GREEN_TIME);
    localparam logic [TW-1:0] YELLOW_DUR = TW'(YELLOW_TIME);
    localparam logic [TW-1:0] RED_DUR    = TW'(ALL_RED_TIME);
    localparam logic [TW-1:0] NIGHT_DUR  = TW'(NIGHT_TIME);

    localparam logic [7:0] LANES_RED       = 8'b0000_0000;
    localparam logic [7:0] LANES_NS_GREEN  = 8'b0011_0011;
    localparam logic [7:0] LANES_NS_YELLOW = 8'b0001_0001;
    localparam logic [7:0] LANES_EW_GREEN  = 8'b1100_1100;
    localparam logic [7:0] LANES_EW_YELLOW = 8'b0100_0100;

    typedef enum logic [2:0] {
        AR_TO_NS  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        AR_TO_EW  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] load_q, load_d;
    logic [7:0]    lanes_q, lanes_d;
    logic          done_q, done_d;
    logic          night_q, night_d;
    logic          enter;
    logic [TW-1:0] dur;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AR_TO_NS;
            timer_q <= RED_DUR - TW'(1);
            load_q  <= RED_DUR;
            lanes_q <= LANES_RED;
            done_q  <= 1'b0;
            night_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            load_q  <= load_d;
            lanes_q <= lanes_d;
            done_q  <= done_d;
            night_q <= night_d;
        end
    end

    // Next-state selection and phase-entry loading
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
        load_d  = load_q;
        lanes_d = lanes_q;
        done_d  = 1'b0;
        night_d = night_q;
        enter   = 1'b0;
        dur     = RED_DUR;

        case (state_q)
            AR_TO_NS: if (timer_q == '0) begin
                state_d = NS_GREEN;
                enter   = 1'b1;
            end
            // Sensors are only looked at once the green has expired; a
            // green with no cross traffic holds at timer 0 without a pulse.
            NS_GREEN: if (timer_q == '0 && (night_q || car_ew)) begin
                state_d = NS_YELLOW;
                enter   = 1'b1;
            end
            NS_YELLOW: if (timer_q == '0) begin
                state_d = AR_TO_EW;
                enter   = 1'b1;
            end
            AR_TO_EW: if (timer_q == '0) begin
                state_d = EW_GREEN;
                enter   = 1'b1;
            end
            EW_GREEN: if (timer_q == '0 && (night_q || car_ns)) begin
                state_d = EW_YELLOW;
                enter   = 1'b1;
            end
            EW_YELLOW: if (timer_q == '0) begin
                state_d = AR_TO_NS;
                enter   = 1'b1;
            end
            // Illegal codes fall back to the N+S clearance phase
            default: begin
                state_d = AR_TO_NS;
                enter   = 1'b1;
            end
        endcase

        if (enter) begin
            case (state_d)
                NS_GREEN: begin
                    dur     = night_mode ? NIGHT_DUR : GREEN_DUR;
                    lanes_d = LANES_NS_GREEN;
                    night_d = night_mode;
                end
                NS_YELLOW: begin
                    dur     = YELLOW_DUR;
                    lanes_d = LANES_NS_YELLOW;
                end
                EW_GREEN: begin
                    dur     = night_mode ? NIGHT_DUR : GREEN_DUR;
                    lanes_d = LANES_EW_GREEN;
                    night_d = night_mode;
                end
                EW_YELLOW: begin
                    dur     = YELLOW_DUR;
                    lanes_d = LANES_EW_YELLOW;
                end
                default: begin
                    dur     = RED_DUR;
                    lanes_d = LANES_RED;
                end
            endcase
            timer_d = dur - TW'(1);
            load_d  = dur;
            done_d  = 1'b1;
        end
    end

    assign phase      = 3'(state_q);
    assign timer      = timer_q;
    assign loadTime   = load_q;
    assign laneOutput = lanes_q;
    assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with GREEN_TIME=8,
// YELLOW_TIME=3, ALL_RED_TIME=2, NIGHT_TIME=4, plus a negedge monitor for
// light safety and phase ordering.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       night_mode;
    logic       car_ns;
    logic       car_ew;
    logic [7:0] laneOutput;
    logic [6:0] loadTime;
    logic [6:0] timer;
    logic [2:0] phase;
    logic       phase_done;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_phase_sequencer #(
        .GREEN_TIME  (8),
        .YELLOW_TIME (3),
        .ALL_RED_TIME(2),
        .NIGHT_TIME  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .night_mode(night_mode),
        .car_ns    (car_ns),
        .car_ew    (car_ew),
        .laneOutput(laneOutput),
        .loadTime  (loadTime),
        .timer     (timer),
        .phase     (phase),
        .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk one whole phase starting at its first output cycle
    task automatic run_phase(input logic [2:0] ph, input int dur, input logic [7:0] lanes,
                             input logic first_done, input int night_at);
        for (int i = 0; i < dur; i++) begin
            if (i == night_at) night_mode = 1'b1;
            check($sformatf("phase p%0d c%0d", ph, i), 32'(phase), 32'(ph));
            check($sformatf("lanes p%0d c%0d", ph, i), 32'(laneOutput), 32'(lanes));
            check($sformatf("timer p%0d c%0d", ph, i), 32'(timer), 32'(dur - 1 - i));
            check($sformatf("load p%0d c%0d", ph, i), 32'(loadTime), 32'(dur));
            check($sformatf("done p%0d c%0d", ph, i), 32'(phase_done),
                  (i == 0) ? 32'(first_done) : 32'd0);
            step();
        end
    endtask

    task automatic day_loop(input logic first_done);
        run_phase(3'd0, 2, 8'h00, first_done, -1);
        run_phase(3'd1, 8, 8'h33, 1'b1, -1);
        run_phase(3'd2, 3, 8'h11, 1'b1, -1);
        run_phase(3'd3, 2, 8'h00, 1'b1, -1);
        run_phase(3'd4, 8, 8'hCC, 1'b1, -1);
        run_phase(3'd5, 3, 8'h44, 1'b1, -1);
    endtask

    // Light safety and legal phase ordering, every cycle
    logic [2:0] prev_ph = 3'd0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            prev_ph = 3'd0;
        end else if (rst === 1'b0) begin
            check("safety", 32'(((laneOutput[7:6] | laneOutput[3:2]) != 2'b00) &&
                                ((laneOutput[5:4] | laneOutput[1:0]) != 2'b00)), 32'd0);
            if (phase != prev_ph)
                check("order", 32'(phase), (prev_ph == 3'd5) ? 32'd0 : 32'(prev_ph + 3'd1));
            prev_ph = phase;
        end
    end

    initial begin
        rst        = 1'b1;
        night_mode = 1'b0;
        car_ns     = 1'b1;
        car_ew     = 1'b1;
        step();
        step();

        // Reset values
        check("rst phase", 32'(phase), 32'd0);
        check("rst lanes", 32'(laneOutput), 32'd0);
        check("rst timer", 32'(timer), 32'd1);
        check("rst load", 32'(loadTime), 32'd2);
        check("rst done", 32'(phase_done), 32'd0);

        // Day cycle with traffic on both streets
        rst = 1'b0;
        day_loop(1'b0);
        run_phase(3'd0, 2, 8'h00, 1'b1, -1);

        // Green hold on N+S with no E+W traffic
        car_ew = 1'b0;
        run_phase(3'd1, 8, 8'h33, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            check("hold phase", 32'(phase), 32'd1);
            check("hold timer", 32'(timer), 32'd0);
            check("hold done", 32'(phase_done), 32'd0);
            check("hold lanes", 32'(laneOutput), 32'h33);
            step();
        end
        car_ew = 1'b1;
        step();
        car_ew = 1'b0;
        run_phase(3'd2, 3, 8'h11, 1'b1, -1);
        run_phase(3'd3, 2, 8'h00, 1'b1, -1);
        run_phase(3'd4, 8, 8'hCC, 1'b1, -1);
        run_phase(3'd5, 3, 8'h44, 1'b1, -1);

        // Night mode, no cars: 18-cycle loop, no holds
        night_mode = 1'b1;
        car_ns     = 1'b0;
        car_ew     = 1'b0;
        run_phase(3'd0, 2, 8'h00, 1'b1, -1);
        run_phase(3'd1, 4, 8'h33, 1'b1, -1);
        run_phase(3'd2, 3, 8'h11, 1'b1, -1);
        run_phase(3'd3, 2, 8'h00, 1'b1, -1);
        run_phase(3'd4, 4, 8'hCC, 1'b1, -1);
        run_phase(3'd5, 3, 8'h44, 1'b1, -1);
        night_mode = 1'b0;
        car_ns     = 1'b1;
        car_ew     = 1'b1;
        run_phase(3'd0, 2, 8'h00, 1'b1, -1);

        // Night mode raised mid-green: this green stays 8, next green loads 4
        run_phase(3'd1, 8, 8'h33, 1'b1, 2);
        run_phase(3'd2, 3, 8'h11, 1'b1, -1);
        run_phase(3'd3, 2, 8'h00, 1'b1, -1);
        check("ew night phase", 32'(phase), 32'd4);
        check("ew night load", 32'(loadTime), 32'd4);
        check("ew night timer", 32'(timer), 32'd3);
        check("ew night done", 32'(phase_done), 32'd1);
        step();
        check("ew night timer2", 32'(timer), 32'd2);

        // Async reset between edges during EW_GREEN
        #2 rst = 1'b1;
        #1;
        check("async phase", 32'(phase), 32'd0);
        check("async lanes", 32'(laneOutput), 32'd0);
        check("async timer", 32'(timer), 32'd1);
        check("async load", 32'(loadTime), 32'd2);
        check("async done", 32'(phase_done), 32'd0);
        night_mode = 1'b0;
        step();
        rst = 1'b0;
        day_loop(1'b0);
        run_phase(3'd0, 2, 8'h00, 1'b1, -1);

        // Random sensors and night mode under the safety monitor
        for (int i = 0; i < 10000; i++) begin
            night_mode = 1'($urandom_range(0, 1));
            car_ns     = 1'($urandom_range(0, 1));
            car_ew     = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Intersection controller that sequences the two lane pairs, N+S and E+W, through green, yellow and all-red phases.
- Drives the 8-bit WWSSEENN light word and exposes the load time of the active phase.
- Holds green on a direction while the cross street has no waiting car (day mode).
- In night mode, alternates N+S and E+W greens on a fixed short duration.

Parameters:
GREEN_TIME, 60, day-mode green duration in cycles (1..127)
YELLOW_TIME, 5, yellow duration in cycles (1..127)
ALL_RED_TIME, 2, all-red clearance duration in cycles (1..127)
NIGHT_TIME, 20, night-mode green duration in cycles (1..127)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
night_mode  input  1  1 = night schedule; sampled only on entry to a green phase
car_ns  input  1  car waiting on N or S approach (level)
car_ew  input  1  car waiting on E or W approach (level)
laneOutput  output  8  light word WWSSEENN; per-light code 11 = green, 01 = yellow, 00 = red
loadTime  output  7  duration loaded on entry to the current phase
timer  output  7  cycles remaining in the current phase, minus 1
phase  output  3  current state encoding
phase_done  output  1  one-cycle pulse in the first cycle of every new phase

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state is registered.
- Reset values, including reset asserted mid-phase:
  - phase = AR_TO_NS (0); laneOutput = 00000000.
  - timer = ALL_RED_TIME-1; loadTime = ALL_RED_TIME; phase_done = 0.
  - Outputs reach these values immediately on rst assertion.
- States, with their laneOutput and duration:
  - AR_TO_NS (0): laneOutput 00000000, duration ALL_RED_TIME.
  - NS_GREEN (1): laneOutput 00110011, duration G.
  - NS_YELLOW (2): laneOutput 00010001, duration YELLOW_TIME.
  - AR_TO_EW (3): laneOutput 00000000, duration ALL_RED_TIME.
  - EW_GREEN (4): laneOutput 11001100, duration G.
  - EW_YELLOW (5): laneOutput 01000100, duration YELLOW_TIME.
  - Codes 6 and 7 are illegal; they recover to AR_TO_NS on the next edge.
- Green duration G: set to NIGHT_TIME if night_mode = 1 in the cycle the green is entered, otherwise GREEN_TIME. Latched in an internal night flag for the whole green.
- Timing: on phase entry, timer = duration-1 and loadTime = duration. timer decrements by 1 each cycle. A phase lasts exactly its duration in cycles, unless held.
- Transitions happen when timer = 0:
  - AR_TO_NS -> NS_GREEN; NS_YELLOW -> AR_TO_EW; AR_TO_EW -> EW_GREEN; EW_YELLOW -> AR_TO_NS.
  - NS_GREEN -> NS_YELLOW if the latched night flag = 1 or car_ew = 1. Otherwise hold in NS_GREEN with timer = 0 and no pulse; leave on the first cycle car_ew = 1.
  - EW_GREEN: symmetric, using car_ns.
- Sensor sampling: sensors are sampled only at timer = 0 in a green. Sensor activity elsewhere is ignored and not remembered.
- phase_done: registered; high for exactly one cycle, coincident with the first cycle of the new phase's outputs. Never high during a hold.
- Light safety:
  - No cycle ever shows a green or yellow on both N+S and E+W bits.
  - Every green is followed by yellow, then by ALL_RED_TIME all-red cycles.
- Width rules: timer and loadTime are 7-bit unsigned; no wrap below 0, since timer holds at 0 during a hold.
- Night mode change mid-green: no effect until the next green entry.

Test Plan:
All scenarios use GREEN_TIME=8, YELLOW_TIME=3, ALL_RED_TIME=2, NIGHT_TIME=4.
- Reset and day cycle: release rst with car_ns = car_ew = 1 -> phase sequence 0(2 cycles), 1(8), 2(3), 3(2), 4(8), 5(3), 0. laneOutput follows 00000000, 00110011, 00010001, 00000000, 11001100, 01000100. phase_done pulses 6 times per 26-cycle loop.
- Green hold: car_ew = 0 during NS_GREEN -> phase stays 1 with timer = 0 indefinitely and no pulse. Assert car_ew for 1 cycle -> next cycle phase = 2, timer = 2, phase_done = 1.
- Night mode: night_mode = 1 and both cars = 0 -> greens last 4 cycles with loadTime = 4; no holds; loop length 18 cycles.
- Mid-green mode change: night_mode 0 -> 1 at cycle 2 of NS_GREEN -> that green still lasts 8 cycles; the next EW_GREEN loads 4.
- Async reset mid-EW_GREEN: assert rst between clock edges -> laneOutput = 00000000, phase = 0, timer = 1 before the next edge. After release, the sequence restarts as in scenario 1.
- Safety assertion, run across all scenarios plus random sensor/night stimulus for 10k cycles: never (laneOutput[7:6] | laneOutput[3:2]) != 0 && (laneOutput[5:4] | laneOutput[1:0]) != 0.
